div32_seq: RTL and testbench

Multi-cycle 32-bit integer divider for the CPU datapath. It computes quotient and remainder by repeated shift-and-subtract: one restoring iteration per clock. It handles signed and unsigned operands, and division by zero is detected and resolved in a single cycle. Results feed the LO (quotient) and HI (remainder) registers, and the control unit sequences it with a start/done handshake.

---
 rtl/div32_seq_if.sv | 40 ++++
 rtl/div32_seq.sv | 137 +++++++++++++
 tb/tb_div32_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/div32_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : div32_seq_if
//  Description : Start/done handshake and operand/result bundle between the
//                control unit (master) and the sequential divider (slave).
//                  start        request, sampled by the divider only in IDLE
//                  signed_op    1 = two's-complement operands, 0 = unsigned
//                  dividend     numerator, sampled with start
//                  divisor      denominator, sampled with start
//                  busy         divider is iterating or fixing up signs
//                  done         one-cycle completion pulse
//                  quotient     LO result, held until the next completion
//                  remainder    HI result, held until the next completion
//                  div_by_zero  last completion had a zero divisor
//  Revision    : 1.0 - initial release
// ============================================================================
interface div32_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/div32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div32_seq
//  Description : Multi-cycle 32-bit signed/unsigned integer divider. One
//                restoring shift-and-subtract iteration per clock on operand
//                magnitudes, followed by a sign fix-up cycle. A zero divisor
//                completes in a single cycle without iterating.
//  Ports       : i_clock    rising-edge clock
//                i_clear_n  asynchronous active-low clear
//                io_bus     div32_seq_if slave modport (handshake, operands,
//                           registered results)
//  Revision    : 1.0 - initial release
// ============================================================================
module div32_seq #(
  parameter int WIDTH = 32   // only 32 is supported
) (
  input  wire        i_clock,
  input  wire        i_clear_n,
  div32_seq_if.slave io_bus
);

  localparam int              c_CW        = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST_ITER = c_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;        // partial remainder (always < divisor)
  logic [WIDTH-1:0] r_quo;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] r_dvs_mag;
  logic [c_CW-1:0]  r_count;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  assign w_dvd_neg = io_bus.signed_op & io_bus.dividend[WIDTH-1];
  assign w_dvs_neg = io_bus.signed_op & io_bus.divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -io_bus.dividend : io_bus.dividend;
  assign w_dvs_mag = w_dvs_neg ? -io_bus.divisor  : io_bus.divisor;

  // The partial remainder stays below the divisor, so it fits in WIDTH bits
  // and the trial value {R, next dividend bit} fits in WIDTH+1 bits.
  assign w_trial = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_dvs_mag};
  // trial < 2*divisor, so a successful subtraction leaves the top bit clear
  // while a failed one wraps and sets it: the top bit is the borrow.
  assign w_fits  = ~w_diff[WIDTH];

  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs_mag   <= '0;
      r_count     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_bus.start) begin
            if (io_bus.divisor == '0) begin
              // Resolved immediately; the iteration path is never entered.
              r_quotient  <= '1;
              r_remainder <= io_bus.dividend;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
            end else begin
              r_dvs_mag <= w_dvs_mag;
              r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r   <= w_dvd_neg;
              r_rem     <= '0;
              r_quo     <= w_dvd_mag;
              r_count   <= '0;
              r_busy    <= 1'b1;
              r_state   <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          r_quo   <= {r_quo[WIDTH-2:0], w_fits};
          r_rem   <= w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_count <= r_count + 1'b1;
          if (r_count == c_LAST_ITER) begin
            r_state <= ST_FIX;
          end
        end

        ST_FIX: begin
          // Modulo-2^WIDTH negation also covers the most-negative / -1 case.
          r_quotient  <= r_neg_q ? -r_quo : r_quo;
          r_remainder <= r_neg_r ? -r_rem : r_rem;
          r_dbz       <= 1'b0;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;
  assign io_bus.quotient    = r_quotient;
  assign io_bus.remainder   = r_remainder;
  assign io_bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div32_seq
//  Description : Self-checking bench for div32_seq: directed vector table,
//                hand-written busy-restart and mid-operation clear sequences,
//                and randomized operands against an arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div32_seq;

  logic r_clock;
  logic r_clear_n;
  int   n_checks;
  int   n_fail;

  div32_seq_if bus ();

  div32_seq dut (
    .i_clock   (r_clock),
    .i_clear_n (r_clear_n),
    .io_bus    (bus)
  );

  initial r_clock = 1'b0;
  always #5 r_clock = ~r_clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        so;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        inj;   // pulse start again while busy
  } vec_t;

  vec_t vec[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Reference: plain language-level arithmetic (SV / and % truncate toward
  // zero with the remainder taking the dividend's sign).
  task automatic model(input logic so, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dbz);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      dbz = 1'b1;
    end else if (so) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q   = 32'(sa / sb);
      r   = 32'(sa % sb);
      dbz = 1'b0;
    end else begin
      q   = a / b;
      r   = a % b;
      dbz = 1'b0;
    end
  endtask

  // Called at a falling edge; start is presented there and accepted on the
  // next rising edge (E0). Returns at the falling edge where done is seen.
  // lat counts rising edges after E0 before that sample.
  task automatic do_div(input logic so, input logic [31:0] a, input logic [31:0] b,
                        input logic inj,
                        output logic [31:0] q, output logic [31:0] r, output logic dbz,
                        output int lat, output int bcyc, output logic busy_at_done);
    bus.start     = 1'b1;
    bus.signed_op = so;
    bus.dividend  = a;
    bus.divisor   = b;
    @(negedge r_clock);
    bus.start     = 1'b0;
    bus.signed_op = 1'($urandom);
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    lat  = 0;
    bcyc = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcyc++;
      if (inj && lat == 5) begin
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd77;
        bus.divisor   = 32'd5;
      end
      if (inj && lat == 6) bus.start = 1'b0;
      @(negedge r_clock);
      lat++;
    end
    q            = bus.quotient;
    r            = bus.remainder;
    dbz          = bus.div_by_zero;
    busy_at_done = bus.busy;
  endtask

  initial begin
    logic [31:0] q, r, eq, er, a, b;
    logic        dbz, edbz, bd, so;
    int          lat, bcyc, n_done, sel;

    n_checks = 0;
    n_fail   = 0;

    vec[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    vec[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 1'b0};
    vec[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 1'b0};
    vec[3]  = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0};
    vec[4]  = '{1'b1, 32'hFFFF_FFFF,  32'd2,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0};
    vec[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0};
    vec[6]  = '{1'b0, 32'd1000,       32'd3,          32'd333,        32'd1,          1'b0, 1'b0};
    vec[7]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1};
    vec[8]  = '{1'b0, 32'd7,          32'd32,         32'd0,          32'd7,          1'b0, 1'b0};
    vec[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0};
    vec[10] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 1'b0};
    vec[11] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 1'b0};
    vec[12] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1'b0};

    // Reset state
    r_clear_n     = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge r_clock);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    r_clear_n = 1'b1;
    @(negedge r_clock);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_div(vec[i].so, vec[i].a, vec[i].b, vec[i].inj, q, r, dbz, lat, bcyc, bd);
      check($sformatf("tbl%0d_quotient", i), q, vec[i].q);
      check($sformatf("tbl%0d_remainder", i), r, vec[i].r);
      check($sformatf("tbl%0d_dbz", i), 32'(dbz), 32'(vec[i].dbz));
      check($sformatf("tbl%0d_latency", i), 32'(lat), vec[i].dbz ? 32'd0 : 32'd33);
      check($sformatf("tbl%0d_busy_cycles", i), 32'(bcyc), vec[i].dbz ? 32'd0 : 32'd33);
      check($sformatf("tbl%0d_busy_at_done", i), 32'(bd), 32'd0);
      @(negedge r_clock);
      check($sformatf("tbl%0d_done_one_cycle", i), 32'(bus.done), 32'd0);
      check($sformatf("tbl%0d_hold_quotient", i), bus.quotient, vec[i].q);
    end

    // Clear in the middle of an operation
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    @(negedge r_clock);
    bus.start = 1'b0;
    repeat (9) @(negedge r_clock);
    check("pre_clear_busy", 32'(bus.busy), 32'd1);
    r_clear_n = 1'b0;
    #1;
    check("clr_busy", 32'(bus.busy), 32'd0);
    check("clr_done", 32'(bus.done), 32'd0);
    check("clr_quotient", bus.quotient, 32'd0);
    check("clr_remainder", bus.remainder, 32'd0);
    check("clr_dbz", 32'(bus.div_by_zero), 32'd0);
    n_done = 0;
    repeat (40) begin
      @(negedge r_clock);
      if (bus.done === 1'b1) n_done++;
    end
    check("clr_no_done", 32'(n_done), 32'd0);
    r_clear_n = 1'b1;
    @(negedge r_clock);
    do_div(1'b0, 32'd1000, 32'd3, 1'b0, q, r, dbz, lat, bcyc, bd);
    check("post_clr_quotient", q, 32'd333);
    check("post_clr_remainder", r, 32'd1);
    check("post_clr_latency", 32'(lat), 32'd33);

    // Randomized, back-to-back (each start coincides with the previous done)
    for (int i = 0; i < 150; i++) begin
      so  = 1'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      b = 32'd0;
      else if (sel <= 3) b = ($urandom_range(0, 1) == 1) ? -32'($urandom_range(1, 15))
                                                         : 32'($urandom_range(1, 15));
      else               b = $urandom;
      a = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
      model(so, a, b, eq, er, edbz);
      do_div(so, a, b, 1'b0, q, r, dbz, lat, bcyc, bd);
      check($sformatf("rnd%0d_quotient a=%h b=%h s=%0d", i, a, b, so), q, eq);
      check($sformatf("rnd%0d_remainder a=%h b=%h s=%0d", i, a, b, so), r, er);
      check($sformatf("rnd%0d_dbz", i), 32'(dbz), 32'(edbz));
      check($sformatf("rnd%0d_latency", i), 32'(lat), edbz ? 32'd0 : 32'd33);
    end

    @(negedge r_clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
